// File: rtl/fact_seq_unit_if.sv
// rtl/fact_seq_unit_if.sv - host request interface for the iterative factorial engine
// Ports carried:
//   go     host -> engine  start request
//   n      host -> engine  operand
//   ack    host -> engine  result consumed (hold-until-ack mode only)
//   busy   engine -> host  engine not idle
//   done   engine -> host  result valid
//   err    engine -> host  overflow occurred (valid with done)
//   result engine -> host  n! modulo 2^WIDTH
interface fact_seq_unit_if #(
  parameter int WIDTH  = 32,
  parameter int NWIDTH = 4
);
  logic              go;
  logic [NWIDTH-1:0] n;
  logic              ack;
  logic              busy;
  logic              done;
  logic              err;
  logic [WIDTH-1:0]  result;

  modport master (
    output go, n, ack,
    input  busy, done, err, result
  );

  modport slave (
    input  go, n, ack,
    output busy, done, err, result
  );
endinterface

// File: rtl/fact_seq_unit.sv
// rtl/fact_seq_unit.sv - parametrised iterative factorial engine with sticky overflow
// Ports:
//   Clk  system clock, rising edge
//   Rst  asynchronous active-low reset
//   bus  fact_seq_unit_if slave: go/n/ack in, busy/done/err/result out
// Parameters:
//   WIDTH    result/product width
//   NWIDTH   operand width (1..WIDTH)
//   ACK_MODE 0: done is a one-cycle pulse; 1: done/result held until ack
module fact_seq_unit #(
  parameter int WIDTH    = 32,
  parameter int NWIDTH   = 4,
  parameter int ACK_MODE = 0
) (
  input  logic         Clk,
  input  logic         Rst,
  fact_seq_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    TEST = 3'd2,
    MULT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [NWIDTH-1:0] cnt;
  logic [WIDTH-1:0]  prod;
  logic              ovf;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [WIDTH-1:0]  result_q;

  // Full-width product so bits above WIDTH can be inspected for overflow.
  logic [WIDTH+NWIDTH-1:0] full;
  assign full = {{NWIDTH{1'b0}}, prod} * {{WIDTH{1'b0}}, cnt};

  // Outputs are registered alongside the state transition so they always
  // reflect the state being entered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      ovf      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.go) begin
            state <= LOAD;
            cnt   <= bus.n;
          end else begin
            busy_q <= 1'b0;
          end
        end
        LOAD: begin
          prod  <= {{(WIDTH-1){1'b0}}, 1'b1};
          ovf   <= 1'b0;
          state <= TEST;
        end
        TEST: begin
          if (cnt > {{(NWIDTH-1){1'b0}}, 1'b1}) begin
            state <= MULT;
          end else begin
            state    <= DONE;
            done_q   <= 1'b1;
            err_q    <= ovf;
            result_q <= prod;
          end
        end
        MULT: begin
          prod  <= full[WIDTH-1:0];
          ovf   <= ovf | (|full[WIDTH+NWIDTH-1:WIDTH]);
          cnt   <= cnt - {{(NWIDTH-1){1'b0}}, 1'b1};
          state <= TEST;
        end
        DONE: begin
          // A go arriving together with ack is dropped: go is only sampled in IDLE.
          if (ACK_MODE == 0 || bus.ack) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
            err_q  <= ovf;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_fact_seq_unit.sv
// tb/tb_fact_seq_unit.sv - self-checking bench for fact_seq_unit in pulse and ack modes
module tb_fact_seq_unit;
  localparam int W  = 32;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fact_seq_unit_if #(.WIDTH(W), .NWIDTH(NW)) if0 ();
  fact_seq_unit_if #(.WIDTH(W), .NWIDTH(NW)) if1 ();

  fact_seq_unit #(.WIDTH(W), .NWIDTH(NW), .ACK_MODE(0)) dut0 (.Clk(clk), .Rst(rst), .bus(if0));
  fact_seq_unit #(.WIDTH(W), .NWIDTH(NW), .ACK_MODE(1)) dut1 (.Clk(clk), .Rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 computing, 2 presenting result
  int             m_mode[2];
  int             m_rem[2];
  logic [W-1:0]   m_res[2];
  logic [W-1:0]   m_pres[2];
  logic           m_ovf[2];
  logic           m_povf[2];

  function automatic logic [63:0] fact(input int k);
    logic [63:0] f;
    f = 64'd1;
    for (int i = 2; i <= k; i++) f = f * i;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_rem[i]  = 0;
      m_res[i]  = '0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic g, input logic [NW-1:0] nn, input logic a);
    logic [63:0] f;
    case (m_mode[i])
      0: if (g) begin
        f          = fact(int'(nn));
        m_pres[i]  = f[W-1:0];
        m_povf[i]  = (f >> W) != 0;
        m_rem[i]   = (nn < 2) ? 2 : 2 * int'(nn);
        m_mode[i]  = 1;
      end
      1: begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_mode[i] = 2;
          m_res[i]  = m_pres[i];
          m_ovf[i]  = m_povf[i];
        end
      end
      default: if (i == 0 || a) m_mode[i] = 0;
    endcase
  endtask

  task automatic cmp_one(input int i, input logic b, input logic d, input logic e, input logic [W-1:0] r);
    check($sformatf("busy%0d", i), 64'(b), 64'(m_mode[i] != 0));
    check($sformatf("done%0d", i), 64'(d), 64'(m_mode[i] == 2));
    check($sformatf("err%0d", i), 64'(e), 64'((m_mode[i] == 2) && m_ovf[i]));
    check($sformatf("result%0d", i), 64'(r), 64'(m_res[i]));
  endtask

  always begin
    @(posedge clk);
    if (rst) begin
      model_step(0, if0.go, if0.n, if0.ack);
      model_step(1, if1.go, if1.n, if1.ack);
    end
    #1;
    cmp_one(0, if0.busy, if0.done, if0.err, if0.result);
    cmp_one(1, if1.busy, if1.done, if1.err, if1.result);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input logic g, input logic [NW-1:0] nn, input logic a);
    if (i == 0) begin
      if0.go = g; if0.n = nn; if0.ack = a;
    end else begin
      if1.go = g; if1.n = nn; if1.ack = a;
    end
  endtask

  function automatic logic o_done(input int i);
    return (i == 0) ? if0.done : if1.done;
  endfunction
  function automatic logic o_busy(input int i);
    return (i == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic o_err(input int i);
    return (i == 0) ? if0.err : if1.err;
  endfunction
  function automatic logic [W-1:0] o_res(input int i);
    return (i == 0) ? if0.result : if1.result;
  endfunction

  // Leaves the bench 1 time unit after the go-sampling edge (cycle 1).
  task automatic start(input int i, input logic [NW-1:0] nn);
    @(negedge clk);
    drive(i, 1'b1, nn, 1'b0);
    @(posedge clk);
    #1;
    drive(i, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_done(input int i, input int c0, output int c);
    c = c0;
    while (!o_done(i) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic timed0(input logic [NW-1:0] nn, input int exp_c, input logic [W-1:0] exp_r, input logic exp_e);
    int c;
    start(0, nn);
    wait_done(0, 1, c);
    check($sformatf("latency n=%0d", nn), 64'(c), 64'(exp_c));
    check($sformatf("value n=%0d", nn), 64'(o_res(0)), 64'(exp_r));
    check($sformatf("err n=%0d", nn), 64'(o_err(0)), 64'(exp_e));
    @(posedge clk);
    #1;
    check($sformatf("pulse n=%0d", nn), 64'(o_done(0)), 64'd0);
    check($sformatf("idle after n=%0d", nn), 64'(o_busy(0)), 64'd0);
  endtask

  initial begin
    int c;
    int dones;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    model_reset();
    #2;
    check("reset busy", 64'(if0.busy), 64'd0);
    check("reset done", 64'(if0.done), 64'd0);
    check("reset result", 64'(if1.result), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Pulse mode latency and value pins.
    timed0(4'd5, 11, 32'd120, 1'b0);
    timed0(4'd0, 3, 32'd1, 1'b0);
    timed0(4'd1, 3, 32'd1, 1'b0);
    timed0(4'd12, 25, 32'd479001600, 1'b0);
    timed0(4'd13, 27, 32'd1932053504, 1'b1);

    // go while busy is ignored.
    start(0, 4'd6);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, '0, 1'b0);
    wait_done(0, 3, c);
    check("ignored-go latency", 64'(c), 64'd13);
    check("ignored-go value", 64'(if0.result), 64'd720);
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (if0.done) dones++;
    end
    check("no second done", 64'(dones), 64'd0);

    // Ack mode: hold, release, and go+ack collision.
    start(1, 4'd4);
    wait_done(1, 1, c);
    check("ack latency", 64'(c), 64'd9);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold done %0d", k), 64'(if1.done), 64'd1);
      check($sformatf("hold result %0d", k), 64'(if1.result), 64'd24);
    end
    @(negedge clk);
    drive(1, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    drive(1, 1'b0, '0, 1'b0);
    check("ack done", 64'(if1.done), 64'd0);
    check("ack busy", 64'(if1.busy), 64'd0);
    check("ack result kept", 64'(if1.result), 64'd24);
    start(1, 4'd4);
    wait_done(1, 1, c);
    @(negedge clk);
    drive(1, 1'b1, 4'd2, 1'b1);
    @(posedge clk);
    #1;
    drive(1, 1'b0, '0, 1'b0);
    check("go+ack busy", 64'(if1.busy), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("go+ack no start", 64'(if1.busy), 64'd0);
    end

    // Asynchronous reset in the middle of a multiply.
    start(0, 4'd9);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check("async busy", 64'(if0.busy), 64'd0);
    check("async done", 64'(if0.done), 64'd0);
    check("async err", 64'(if0.err), 64'd0);
    check("async result", 64'(if0.result), 64'd0);
    check("async result1", 64'(if1.result), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    timed0(4'd3, 7, 32'd6, 1'b0);

    // Randomized traffic on both instances, with occasional between-edge resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      drive(0, $urandom_range(0, 3) == 0, NW'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
      drive(1, $urandom_range(0, 3) == 0, NW'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b1);
    repeat (40) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
